dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipelined MIPS CPU's EX-stage memory interface and a DMA/debug loader requester.
- CPU has fixed priority. A starvation counter forces one CPU stall cycle so the DMA side is guaranteed progress.
- Sits between the CPU's data-memory outputs and the synchronous data RAM, which has 1-cycle read latency.
- Drives the CPU stall that is ANDed into the global pipeline enable.

Parameters:
- STARVE_LIMIT, 8: consecutive denied DMA-request cycles before a steal cycle is forced; legal range 1..255.
- CNT_W, 8: width of the starvation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_en  in  1  global CPU enable (pre-stall)
- cpu_we  in  4  CPU byte write enables, bit3 = addr[1:0]==0 lane
- cpu_re  in  1  CPU read enable
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  read data to CPU M stage
- cpu_stall  out  1  CPU must hold all pipeline registers this cycle
- dma_req  in  1  DMA access request, held until granted
- dma_we  in  4  DMA byte write enables (all zero = read)
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  DMA access issued to memory this cycle
- dma_rvalid  out  1  DMA read data valid, 1 cycle after a read grant
- dma_rdata  out  32  DMA read data
- mem_we  out  4  RAM byte write enables
- mem_re  out  1  RAM read enable
- mem_addr  out  32  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_re

Behaviour:
- cpu_acc = cpu_en & ~cpu_stall & (cpu_re | |cpu_we).
- States: NORMAL, STEAL. Reset state is NORMAL.
- NORMAL:
  - cpu_stall = 0.
  - If cpu_acc: the CPU owns the port and dma_gnt = 0.
  - Otherwise dma_gnt = dma_req and the DMA owns the port.
- STEAL:
  - cpu_stall = 1; CPU requests are masked.
  - dma_gnt = dma_req.
  - Always returns to NORMAL after exactly 1 cycle.
  - If dma_req dropped, the steal cycle is wasted; this is intended.
- Starvation counter, cnt:
  - Increments when dma_req & ~dma_gnt.
  - Clears on dma_gnt or when ~dma_req.
  - Saturates; it never wraps.
  - When the increment would make cnt == STARVE_LIMIT, the next state is STEAL and cnt clears.
- Memory mux (combinational):
  - With no owner, mem_we = 0 and mem_re = 0.
  - mem_addr and mem_wdata follow the CPU whenever the DMA does not own the port.
- Read return:
  - Registered owner_q ∈ {NONE, CPU_RD, DMA_RD} records the previous cycle's read owner.
  - dma_rvalid = (owner_q == DMA_RD); dma_rdata = mem_rdata.
  - cpu_rdata = mem_rdata when owner_q == CPU_RD; otherwise it is cpu_rdata_q.
  - cpu_rdata_q captures mem_rdata whenever owner_q == CPU_RD. This holds the CPU's load data stable while the M stage is frozen by a steal.
- Simultaneous events:
  - CPU access and DMA request in NORMAL: the CPU wins.
  - cpu_en = 0: the DMA is granted every requesting cycle.
- Latency:
  - Grant is combinational in the request cycle.
  - Read data arrives 1 cycle after the grant.
  - Worst-case DMA wait is STARVE_LIMIT cycles of denial, then grant in the steal cycle.
- Reset (asynchronous, mid-operation included):
  - State = NORMAL; cnt, owner_q, cpu_rdata_q = 0.
  - dma_rvalid = 0, cpu_stall = 0.
  - Any in-flight read is discarded.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, adds two output ports:
  - perf_steal_cnt (32): number of STEAL cycles.
  - perf_dma_gnt_cnt (32): number of dma_gnt cycles.
- Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst_n.
- When not defined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-transfer, then release → cpu_stall=0, dma_gnt=0, dma_rvalid=0, mem_we=4'h0, mem_re=0.
- Idle CPU: cpu_en=1, no CPU access; DMA read addr 0x40, RAM returns 0xDEADBEEF → dma_gnt=1 same cycle; next cycle dma_rvalid=1, dma_rdata=0xDEADBEEF.
- Contention: CPU write cpu_we=4'hF to 0x100 while dma_req=1 → mem_we=4'hF, mem_addr=0x100, dma_gnt=0, cnt increments.
- Starvation: CPU accesses every cycle with STARVE_LIMIT=8 and dma_req held → 8 denied cycles, then 1 cycle of cpu_stall=1 with dma_gnt=1, then NORMAL with cnt=0.
- Load across steal: CPU load returns 0x12345678, steal occurs next cycle, then DMA reads 0xAAAA5555 → cpu_rdata stays 0x12345678 during the steal; dma_rdata=0xAAAA5555.
- Perf (DMEM_ARB_PERF_EN): after the starvation scenario run twice → perf_steal_cnt=2, perf_dma_gnt_cnt=2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU has fixed priority, and a starvation counter forces one CPU stall cycle for the DMA.
// Optional DMEM_ARB_PERF_EN adds saturating steal / DMA-grant performance counters.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cpu_en,
   input  logic [3:0]  i_cpu_we,
   input  logic        i_cpu_re,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wdata,
   output logic [31:0] o_cpu_rdata,
   output logic        o_cpu_stall,
   input  logic        i_dma_req,
   input  logic [3:0]  i_dma_we,
   input  logic [31:0] i_dma_addr,
   input  logic [31:0] i_dma_wdata,
   output logic        o_dma_gnt,
   output logic        o_dma_rvalid,
   output logic [31:0] o_dma_rdata,
   output logic [3:0]  o_mem_we,
   output logic        o_mem_re,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0] o_perf_steal_cnt,
   output logic [31:0] o_perf_dma_gnt_cnt
`endif
);

   typedef enum logic {NORMAL, STEAL} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_DMA_RD} owner_t;

   state_t             r_state, w_state_nxt;
   owner_t             r_owner_q, w_owner_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [31:0]        r_cpu_rdata_q;
   logic               w_cpu_acc;
   logic               w_dma_rd;

   assign o_cpu_stall = (r_state == STEAL);
   // In STEAL the stall itself masks the CPU, so the DMA wins whatever it asks.
   assign w_cpu_acc   = i_cpu_en & ~o_cpu_stall & (i_cpu_re | (|i_cpu_we));
   assign o_dma_gnt   = i_dma_req & ~w_cpu_acc;
   assign w_dma_rd    = o_dma_gnt & ~(|i_dma_we);
   assign w_cnt_inc   = r_cnt + CNT_W'(1);

   always_comb begin
      o_mem_we    = 4'h0;
      o_mem_re    = 1'b0;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      if (o_dma_gnt) begin
         o_mem_we    = i_dma_we;
         o_mem_re    = w_dma_rd;
         o_mem_addr  = i_dma_addr;
         o_mem_wdata = i_dma_wdata;
      end else if (w_cpu_acc) begin
         o_mem_we = i_cpu_we;
         o_mem_re = i_cpu_re;
      end
   end

   always_comb begin
      w_state_nxt = NORMAL;
      w_cnt_nxt   = '0;
      if (i_dma_req & ~o_dma_gnt) begin
         if (w_cnt_inc == CNT_W'(STARVE_LIMIT)) begin
            w_state_nxt = STEAL;
         end else if (r_cnt != '1) begin
            w_cnt_nxt = w_cnt_inc;
         end else begin
            w_cnt_nxt = r_cnt;
         end
      end
   end

   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (w_cpu_acc & i_cpu_re & ~o_dma_gnt) w_owner_nxt = OWN_CPU_RD;
      else if (w_dma_rd)                     w_owner_nxt = OWN_DMA_RD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= NORMAL;
         r_cnt         <= '0;
         r_owner_q     <= OWN_NONE;
         r_cpu_rdata_q <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_owner_q <= w_owner_nxt;
         if (r_owner_q == OWN_CPU_RD) r_cpu_rdata_q <= i_mem_rdata;
      end
   end

   // Load data is held so a frozen M stage keeps seeing its value during a steal.
   assign o_cpu_rdata  = (r_owner_q == OWN_CPU_RD) ? i_mem_rdata : r_cpu_rdata_q;
   assign o_dma_rvalid = (r_owner_q == OWN_DMA_RD);
   assign o_dma_rdata  = i_mem_rdata;

`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_perf_steal_cnt   <= '0;
         o_perf_dma_gnt_cnt <= '0;
      end else begin
         if (o_cpu_stall && o_perf_steal_cnt != 32'hFFFF_FFFF)
            o_perf_steal_cnt <= o_perf_steal_cnt + 32'd1;
         if (o_dma_gnt && o_perf_dma_gnt_cnt != 32'hFFFF_FFFF)
            o_perf_dma_gnt_cnt <= o_perf_dma_gnt_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a word-RAM environment, a rule-level reference model checked every cycle, and directed literal checks.
module tb_dmem_arbiter;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_en, cpu_re, dma_req;
   logic [3:0]  cpu_we, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        cpu_stall, dma_gnt, dma_rvalid, mem_re;
   logic [3:0]  mem_we;
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_steal, perf_gnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cpu_en(cpu_en), .i_cpu_we(cpu_we), .i_cpu_re(cpu_re),
      .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
      .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
      .i_dma_wdata(dma_wdata), .o_dma_gnt(dma_gnt),
      .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
      .o_mem_we(mem_we), .o_mem_re(mem_re), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
      , .o_perf_steal_cnt(perf_steal), .o_perf_dma_gnt_cnt(perf_gnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous RAM environment, bit3 of we = byte lane [31:24].
   logic [31:0] ram [256];
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= ram[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: steal flag, run length of denied requests, last read.
   bit          m_steal = 0;
   int          m_deny = 0;
   int          m_prev = 0;          // 0 none, 1 cpu read, 2 dma read
   logic [31:0] m_prev_data = 0;
   logic [31:0] m_hold = 0;
   logic [31:0] mm [256];

   function automatic void model_comb(output bit acc, output bit gnt);
      acc = !m_steal && cpu_en && (cpu_re || cpu_we != 4'h0);
      gnt = dma_req && !acc;
   endfunction

   always @(negedge clk) begin
      bit acc, gnt;
      logic [3:0] e_we;
      logic       e_re;
      if (!rst_n) begin
         chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
         chk("rst_rvalid", {31'b0, dma_rvalid}, 32'd0);
         chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      end else begin
         model_comb(acc, gnt);
         e_we = gnt ? dma_we : (acc ? cpu_we : 4'h0);
         e_re = gnt ? (dma_we == 4'h0) : (acc ? cpu_re : 1'b0);
         chk("m_stall", {31'b0, cpu_stall}, {31'b0, m_steal});
         chk("m_gnt", {31'b0, dma_gnt}, {31'b0, gnt});
         chk("m_mem_we", {28'b0, mem_we}, {28'b0, e_we});
         chk("m_mem_re", {31'b0, mem_re}, {31'b0, e_re});
         chk("m_mem_addr", mem_addr, gnt ? dma_addr : cpu_addr);
         chk("m_mem_wdata", mem_wdata, gnt ? dma_wdata : cpu_wdata);
         chk("m_rvalid", {31'b0, dma_rvalid}, {31'b0, m_prev == 2});
         if (m_prev == 2) chk("m_dma_rdata", dma_rdata, m_prev_data);
         chk("m_cpu_rdata", cpu_rdata, (m_prev == 1) ? m_prev_data : m_hold);
      end
   end

   always @(posedge clk) begin
      bit acc, gnt;
      logic [3:0] e_we;
      if (!rst_n) begin
         m_steal = 0; m_deny = 0; m_prev = 0; m_prev_data = 0; m_hold = 0;
      end else begin
         model_comb(acc, gnt);
         if (m_prev == 1) m_hold = m_prev_data;
         if (acc && !gnt && cpu_re) begin
            m_prev = 1; m_prev_data = mm[cpu_addr[9:2]];
         end else if (gnt && dma_we == 4'h0) begin
            m_prev = 2; m_prev_data = mm[dma_addr[9:2]];
         end else m_prev = 0;
         e_we = gnt ? dma_we : (acc ? cpu_we : 4'h0);
         for (int b = 0; b < 4; b++)
            if (e_we[b]) mm[(gnt ? dma_addr[9:2] : cpu_addr[9:2])][b*8 +: 8] =
                           (gnt ? dma_wdata[b*8 +: 8] : cpu_wdata[b*8 +: 8]);
         if (dma_req && !gnt) begin
            m_deny++;
            m_steal = (m_deny == LIMIT);
            if (m_steal) m_deny = 0;
         end else begin
            m_deny = 0;
            m_steal = 0;
         end
      end
   end

   task automatic idle();
      cpu_en = 1; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic dma_set(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
   endtask

   task automatic check_idle_reset(input string tag);
      chk({tag, "_stall"}, {31'b0, cpu_stall}, 32'd0);
      chk({tag, "_gnt"}, {31'b0, dma_gnt}, 32'd0);
      chk({tag, "_rvalid"}, {31'b0, dma_rvalid}, 32'd0);
      chk({tag, "_mem_we"}, {28'b0, mem_we}, 32'd0);
      chk({tag, "_mem_re"}, {31'b0, mem_re}, 32'd0);
   endtask

   initial begin
      logic [31:0] pre_a [3];
      logic [31:0] pre_d [3];
      for (int i = 0; i < 256; i++) begin ram[i] = 0; mm[i] = 0; end
      pre_a[0] = 32'h40;  pre_d[0] = 32'hDEADBEEF;
      pre_a[1] = 32'h300; pre_d[1] = 32'h12345678;
      pre_a[2] = 32'h80;  pre_d[2] = 32'hAAAA5555;
      idle();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk); check_idle_reset("reset");

      // Preload through DMA writes with the CPU idle.
      for (int i = 0; i < 3; i++) begin
         tick(); dma_set(4'hF, pre_a[i], pre_d[i]);
         @(negedge clk); chk("pre_gnt", {31'b0, dma_gnt}, 32'd1);
      end
      tick(); idle();

      // Idle CPU, DMA read of 0x40.
      tick(); dma_set(4'h0, 32'h40, 32'h0);
      @(negedge clk);
      chk("idle_gnt", {31'b0, dma_gnt}, 32'd1);
      chk("idle_mem_re", {31'b0, mem_re}, 32'd1);
      tick(); idle();
      @(negedge clk);
      chk("idle_rvalid", {31'b0, dma_rvalid}, 32'd1);
      chk("idle_rdata", dma_rdata, 32'hDEADBEEF);

      // Contention: CPU write wins, then partial write, then read back.
      tick(); cpu_we = 4'hF; cpu_addr = 32'h100; cpu_wdata = 32'hCAFEF00D;
      dma_set(4'h0, 32'h200, 32'h0);
      @(negedge clk);
      chk("cont_mem_we", {28'b0, mem_we}, 32'hF);
      chk("cont_mem_addr", mem_addr, 32'h100);
      chk("cont_gnt", {31'b0, dma_gnt}, 32'd0);
      tick(); cpu_we = 4'h3; cpu_wdata = 32'h0000BEEF;
      tick(); cpu_we = 4'h0; cpu_re = 1; dma_req = 0;
      tick(); idle();
      @(negedge clk); chk("partial_rd", cpu_rdata, 32'hCAFEBEEF);

      // CPU disabled: DMA granted every requesting cycle.
      tick(); cpu_en = 0; cpu_re = 1; cpu_addr = 32'h300; dma_set(4'h0, 32'h40, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("cpuoff_gnt", {31'b0, dma_gnt}, 32'd1);
         chk("cpuoff_addr", mem_addr, 32'h40);
         if (i < 2) tick();
      end
      tick(); idle();

      // Mid-transfer reset discards the in-flight DMA read.
      tick(); dma_set(4'h0, 32'h80, 32'h0);
      @(negedge clk); #1 rst_n = 0; idle();
      @(posedge clk); @(negedge clk);
      chk("midrst_rvalid", {31'b0, dma_rvalid}, 32'd0);
      tick(); rst_n = 1;
      @(negedge clk); check_idle_reset("release");

      // Starvation with a CPU load crossing the steal cycle, run twice.
      for (int r = 0; r < 2; r++) begin
         for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
               cpu_en = 1; cpu_re = 1; cpu_addr = 32'h300;
               dma_set(4'h0, 32'h80, 32'h0);
            end
            if (c == 10) dma_req = 0;
            @(negedge clk);
            if (c <= LIMIT) begin
               chk("starve_gnt", {31'b0, dma_gnt}, 32'd0);
               chk("starve_stall", {31'b0, cpu_stall}, 32'd0);
            end else if (c == LIMIT + 1) begin
               chk("steal_stall", {31'b0, cpu_stall}, 32'd1);
               chk("steal_gnt", {31'b0, dma_gnt}, 32'd1);
               chk("steal_cpu_rdata", cpu_rdata, 32'h12345678);
            end else begin
               chk("post_stall", {31'b0, cpu_stall}, 32'd0);
               chk("post_rvalid", {31'b0, dma_rvalid}, 32'd1);
               chk("post_dma_rdata", dma_rdata, 32'hAAAA5555);
               chk("post_cpu_rdata", cpu_rdata, 32'h12345678);
            end
         end
         tick(); idle();
      end
      tick();
`ifdef DMEM_ARB_PERF_EN
      chk("perf_steal", perf_steal, 32'd2);
      chk("perf_gnt", perf_gnt, 32'd2);
`endif
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
